// File: rtl/speaker_pcm_if.sv
// rtl/speaker_pcm_if.sv - PCM sample stream from speaker_pcm to the audio mixer
interface speaker_pcm_if;
  logic [15:0] sample_out;
  logic        sample_strobe;

  modport master (output sample_out, output sample_strobe);
  modport slave  (input  sample_out, input  sample_strobe);
endinterface

// File: rtl/speaker_pcm.sv
// rtl/speaker_pcm.sv - PC speaker bit to 48 kHz signed PCM; optional DC blocker via SPEAKER_PCM_DCBLOCK_EN
module speaker_pcm #(
  parameter int OVS_RATE = 1536000,
  parameter int MIN_CLK  = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] clock_rate,
  input  logic        speaker_in,
  input  logic [1:0]  volume,
  speaker_pcm_if.master pcm
);

  localparam logic [27:0] OVS_STEP = 28'(OVS_RATE);
  localparam logic [27:0] MIN_RATE = 28'(MIN_CLK);

  logic [27:0] rate_q;
  logic [27:0] acc;
  logic [4:0]  tick_cnt;
  logic [5:0]  high_cnt;
  logic [15:0] sample_q;
  logic        strobe_q;

  logic        enabled;
  logic [28:0] acc_sum;
  logic        tick;
  logic [27:0] acc_new;
  logic        boundary;
  logic [5:0]  count;
  logic signed [15:0] raw;
  logic signed [15:0] level;
  logic signed [15:0] out_val;

  always_comb begin
    enabled  = (rate_q >= MIN_RATE);
    // 29-bit sum so a rate near the top of the 28-bit range cannot wrap the compare
    acc_sum  = {1'b0, acc} + {1'b0, OVS_STEP};
    tick     = enabled && (acc_sum >= {1'b0, rate_q});
    acc_new  = tick ? (acc_sum[27:0] - rate_q) : acc_sum[27:0];
    boundary = tick && (tick_cnt == 5'd31);
    count    = high_cnt + {5'd0, speaker_in};
    // c*2048 - 32768 for c<32 is c<<11 with the sign bit flipped
    raw      = count[5] ? 16'sh7FFF : $signed({~count[4], count[3:0], 11'b0});
    level    = raw >>> volume;
  end

`ifdef SPEAKER_PCM_DCBLOCK_EN
  logic signed [15:0] x_prev;
  logic signed [15:0] y_prev;
  logic signed [15:0] y_leak;
  logic signed [18:0] dc_sum;

  always_comb begin
    y_leak = y_prev >>> 8;
    dc_sum = {{3{level[15]}}, level} - {{3{x_prev[15]}}, x_prev}
           + {{3{y_prev[15]}}, y_prev} - {{3{y_leak[15]}}, y_leak};
    if (dc_sum > 19'sd32767)
      out_val = 16'sh7FFF;
    else if (dc_sum < -19'sd32768)
      out_val = 16'sh8000;
    else
      out_val = dc_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst || !enabled) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (boundary) begin
      x_prev <= level;
      y_prev <= out_val;
    end
  end
`else
  always_comb out_val = level;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q <= '0;
    end else begin
      rate_q <= clock_rate;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enabled) begin
      acc      <= '0;
      tick_cnt <= '0;
      high_cnt <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      acc      <= acc_new;
      strobe_q <= boundary;
      if (tick) begin
        tick_cnt <= tick_cnt + 5'd1;
        high_cnt <= boundary ? 6'd0 : count;
      end
      if (boundary) begin
        sample_q <= out_val;
      end
    end
  end

  assign pcm.sample_out    = sample_q;
  assign pcm.sample_strobe = strobe_q;

endmodule

// File: tb/tb_speaker_pcm.sv
// tb/tb_speaker_pcm.sv - scoreboard bench for speaker_pcm
module tb_speaker_pcm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] clock_rate = 28'd3072000;
  logic        speaker_in = 1'b1;
  logic [1:0]  volume = 2'd0;

  speaker_pcm_if pcm();

  speaker_pcm dut (
    .clk        (clk),
    .rst        (rst),
    .clock_rate (clock_rate),
    .speaker_in (speaker_in),
    .volume     (volume),
    .pcm        (pcm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_val[$];
  int          exp_cyc[$];
  logic signed [15:0] m_xp = '0;
  logic signed [15:0] m_yp = '0;
  logic [15:0] mon_v;
  int          mon_c;
  int          base;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    m_xp = '0;
    m_yp = '0;
  endtask

  // expected output for a given pre-filter level, arriving at the given cycle
  task automatic push(input logic signed [15:0] level, input int at);
    logic signed [15:0] y;
`ifdef SPEAKER_PCM_DCBLOCK_EN
    logic signed [15:0] leak;
    logic signed [18:0] s;
    leak = m_yp >>> 8;
    s = {{3{level[15]}}, level} - {{3{m_xp[15]}}, m_xp}
      + {{3{m_yp[15]}}, m_yp} - {{3{leak[15]}}, leak};
    if (s > 19'sd32767) y = 16'sh7FFF;
    else if (s < -19'sd32768) y = 16'sh8000;
    else y = s[15:0];
    m_xp = level;
    m_yp = y;
`else
    y = level;
`endif
    exp_val.push_back(y);
    exp_cyc.push_back(at);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic reset_pulse(input int n, output int b);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
    b = cyc;
    model_clear();
  endtask

  always @(negedge clk) begin
    if (pcm.sample_strobe) begin
      if (exp_val.size() == 0) begin
        check("unexpected_strobe", int'(pcm.sample_strobe), 0);
      end else begin
        mon_v = exp_val.pop_front();
        mon_c = exp_cyc.pop_front();
        check("sample_value", int'($signed(pcm.sample_out)), int'($signed(mon_v)));
        check("strobe_cycle", cyc, mon_c);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int d;
    int w;
    step(3);
    check("reset_sample_out", int'(pcm.sample_out), 0);
    check("reset_strobe", int'(pcm.sample_strobe), 0);

    // full-scale high at 3.072 MHz: tick every 2 clk
    reset_pulse(1, base);
    push(16'sd32767, base + 65);
    push(16'sd32767, base + 129);
    push(16'sd32767, base + 193);
    step_to(base + 195);

    // 16 ticks high then 16 low per sample window
    reset_pulse(2, base);
    push(16'sd0, base + 65);
    push(16'sd0, base + 129);
    push(16'sd0, base + 193);
    while (cyc < base + 195) begin
      d = cyc + 1 - base - 3;
      speaker_in = (d >= 0 && (d % 64) < 32) ? 1'b1 : 1'b0;
      step(1);
    end

    // silence at volume 2
    speaker_in = 1'b0;
    volume = 2'd2;
    reset_pulse(2, base);
    push(-16'sd8192, base + 65);
    push(-16'sd8192, base + 129);
    step_to(base + 131);

    // below MIN_CLK: no output, then re-enable
    speaker_in = 1'b1;
    volume = 2'd0;
    clock_rate = 28'd1000000;
    reset_pulse(2, base);
    repeat (4) begin
      step(500);
      check("disabled_sample_out", int'(pcm.sample_out), 0);
      check("disabled_strobe", int'(pcm.sample_strobe), 0);
    end
    clock_rate = 28'd3072000;
    base = cyc;
    model_clear();
    push(16'sd32767, base + 65);
    step_to(base + 67);

    // one-cycle reset 40 clk into a window discards the partial count
    reset_pulse(2, base);
    step_to(base + 39);
    rst = 1'b1;
    step(1);
    check("midreset_sample_out", int'(pcm.sample_out), 0);
    check("midreset_strobe", int'(pcm.sample_strobe), 0);
    rst = 1'b0;
    base = cyc;
    model_clear();
    push(16'sd32767, base + 65);
    step(1);
    check("post_reset_sample_out", int'(pcm.sample_out), 0);
    step_to(base + 67);

    // volume change mid-window applies at that boundary
    reset_pulse(2, base);
    push(16'sd4095, base + 65);
    step_to(base + 30);
    volume = 2'd3;
    step_to(base + 67);
    rst = 1'b1;
    step(2);

    w = 0;
    while (exp_val.size() > 0 && w < 200) begin
      step(1);
      w++;
    end
    check("missing_strobe", exp_val.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
